// File: rtl/ctrl_pipeline.sv
// Control-word pipeline: carries decoded control bits from ID through EX, MEM and WB,
// detects load-use hazards, resolves branches/jumps in EX and counts stalls and flushes.
module ctrl_pipeline #(
    parameter int CNT_W    = 16,
    parameter int LINK_REG = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    input  logic             id_valid,
    input  logic [9:0]       id_ctrl,
    input  logic             id_bne,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic [4:0]       id_rd,
    input  logic             ex_zero,
    output logic             ex_valid,
    output logic             ex_alusrc,
    output logic             ex_branch,
    output logic             ex_bne,
    output logic             ex_jump,
    output logic [1:0]       ex_aluop,
    output logic [4:0]       ex_dest,
    output logic             mem_valid,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic             mem_memtoreg,
    output logic             mem_regwrite,
    output logic [4:0]       mem_dest,
    output logic             wb_valid,
    output logic             wb_regwrite,
    output logic             wb_memtoreg,
    output logic             wb_link,
    output logic [4:0]       wb_dest,
    output logic             pc_write_en,
    output logic             ifid_write_en,
    output logic             ifid_flush,
    output logic             redirect,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [4:0] LINK_DEST = 5'(LINK_REG);

    logic       ex_memread_int;
    logic       ex_memwrite_int;
    logic       ex_memtoreg_int;
    logic       ex_regwrite_int;
    logic       ex_link_int;
    logic       mem_link_int;

    logic       id_link;
    logic [4:0] id_dest;
    logic       id_regwrite;
    logic       taken;
    logic       load_use;
    logic       idex_bubble;
    logic       stall_inc;
    logic       flush_inc;

    // Destination resolution: JAL writes the link register, otherwise rd or rt.
    always_comb begin
        id_link = id_ctrl[2] & id_ctrl[6];
        if (id_link)
            id_dest = LINK_DEST;
        else if (id_ctrl[9])
            id_dest = id_rd;
        else
            id_dest = id_rt;
        id_regwrite = id_ctrl[6] & (id_dest != 5'd0);
    end

    always_comb begin
        taken = ex_valid & ((ex_branch & (ex_bne ? ~ex_zero : ex_zero)) | ex_jump);
        load_use = ex_valid & ex_memread_int & id_valid & (ex_dest != 5'd0) &
                   ((ex_dest == id_rs) | (ex_dest == id_rt));
        idex_bubble   = taken | load_use;
        flush_inc     = ~hold & taken;
        stall_inc     = ~hold & ~taken & load_use;
        pc_write_en   = ~hold & ~stall_inc;
        ifid_write_en = ~hold & ~stall_inc;
        ifid_flush    = flush_inc;
        redirect      = flush_inc;
    end

    // ID/EX register; an invalid or squashed slot is loaded as an all-zero bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid        <= 1'b0;
            ex_alusrc       <= 1'b0;
            ex_branch       <= 1'b0;
            ex_bne          <= 1'b0;
            ex_jump         <= 1'b0;
            ex_aluop        <= 2'b00;
            ex_dest         <= 5'd0;
            ex_memread_int  <= 1'b0;
            ex_memwrite_int <= 1'b0;
            ex_memtoreg_int <= 1'b0;
            ex_regwrite_int <= 1'b0;
            ex_link_int     <= 1'b0;
        end else if (!hold) begin
            if (idex_bubble || !id_valid) begin
                ex_valid        <= 1'b0;
                ex_alusrc       <= 1'b0;
                ex_branch       <= 1'b0;
                ex_bne          <= 1'b0;
                ex_jump         <= 1'b0;
                ex_aluop        <= 2'b00;
                ex_dest         <= 5'd0;
                ex_memread_int  <= 1'b0;
                ex_memwrite_int <= 1'b0;
                ex_memtoreg_int <= 1'b0;
                ex_regwrite_int <= 1'b0;
                ex_link_int     <= 1'b0;
            end else begin
                ex_valid        <= 1'b1;
                ex_alusrc       <= id_ctrl[8];
                ex_branch       <= id_ctrl[3];
                ex_bne          <= id_bne & id_ctrl[3];
                ex_jump         <= id_ctrl[2];
                ex_aluop        <= id_ctrl[1:0];
                ex_dest         <= id_dest;
                ex_memread_int  <= id_ctrl[5];
                ex_memwrite_int <= id_ctrl[4];
                ex_memtoreg_int <= id_ctrl[7];
                ex_regwrite_int <= id_regwrite;
                ex_link_int     <= id_link;
            end
        end
    end

    // EX/MEM and MEM/WB always advance unless held; EX fields are already zero for bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid    <= 1'b0;
            mem_memread  <= 1'b0;
            mem_memwrite <= 1'b0;
            mem_memtoreg <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_dest     <= 5'd0;
            mem_link_int <= 1'b0;
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_memtoreg  <= 1'b0;
            wb_link      <= 1'b0;
            wb_dest      <= 5'd0;
        end else if (!hold) begin
            mem_valid    <= ex_valid;
            mem_memread  <= ex_valid & ex_memread_int;
            mem_memwrite <= ex_valid & ex_memwrite_int;
            mem_memtoreg <= ex_memtoreg_int;
            mem_regwrite <= ex_valid & ex_regwrite_int;
            mem_dest     <= ex_dest;
            mem_link_int <= ex_valid & ex_link_int;
            wb_valid     <= mem_valid;
            wb_regwrite  <= mem_valid & mem_regwrite;
            wb_memtoreg  <= mem_memtoreg;
            wb_link      <= mem_valid & mem_link_int;
            wb_dest      <= mem_dest;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_inc && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Directed bench for ctrl_pipeline: a default instance plus a narrow-counter
// instance (CNT_W=3) sharing the same stimulus to exercise counter saturation.
module tb_ctrl_pipeline;

    localparam logic [9:0] C_ADDI = 10'b0101000000;
    localparam logic [9:0] C_LW   = 10'b0111100000;
    localparam logic [9:0] C_ADD  = 10'b1001000010;
    localparam logic [9:0] C_BEQ  = 10'b0000001001;
    localparam logic [9:0] C_JAL  = 10'b0001000100;

    logic clk = 1'b0;
    logic rst_n, hold, id_valid, id_bne, ex_zero;
    logic [9:0] id_ctrl;
    logic [4:0] id_rs, id_rt, id_rd;

    logic ex_valid, ex_alusrc, ex_branch, ex_bne, ex_jump;
    logic [1:0] ex_aluop;
    logic [4:0] ex_dest, mem_dest, wb_dest;
    logic mem_valid, mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite;
    logic wb_valid, wb_regwrite, wb_memtoreg, wb_link;
    logic pc_write_en, ifid_write_en, ifid_flush, redirect;
    logic [15:0] stall_cnt, flush_cnt;

    logic s_ex_valid, s_ex_alusrc, s_ex_branch, s_ex_bne, s_ex_jump;
    logic [1:0] s_ex_aluop;
    logic [4:0] s_ex_dest, s_mem_dest, s_wb_dest;
    logic s_mem_valid, s_mem_memread, s_mem_memwrite, s_mem_memtoreg, s_mem_regwrite;
    logic s_wb_valid, s_wb_regwrite, s_wb_memtoreg, s_wb_link;
    logic s_pc_write_en, s_ifid_write_en, s_ifid_flush, s_redirect;
    logic [2:0] s_stall_cnt, s_flush_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ctrl_pipeline dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_bne(id_bne), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
        .ex_valid(ex_valid), .ex_alusrc(ex_alusrc), .ex_branch(ex_branch), .ex_bne(ex_bne),
        .ex_jump(ex_jump), .ex_aluop(ex_aluop), .ex_dest(ex_dest),
        .mem_valid(mem_valid), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_memtoreg(mem_memtoreg), .mem_regwrite(mem_regwrite), .mem_dest(mem_dest),
        .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg),
        .wb_link(wb_link), .wb_dest(wb_dest), .pc_write_en(pc_write_en),
        .ifid_write_en(ifid_write_en), .ifid_flush(ifid_flush), .redirect(redirect),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    ctrl_pipeline #(.CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .hold(hold), .id_valid(id_valid), .id_ctrl(id_ctrl),
        .id_bne(id_bne), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
        .ex_valid(s_ex_valid), .ex_alusrc(s_ex_alusrc), .ex_branch(s_ex_branch), .ex_bne(s_ex_bne),
        .ex_jump(s_ex_jump), .ex_aluop(s_ex_aluop), .ex_dest(s_ex_dest),
        .mem_valid(s_mem_valid), .mem_memread(s_mem_memread), .mem_memwrite(s_mem_memwrite),
        .mem_memtoreg(s_mem_memtoreg), .mem_regwrite(s_mem_regwrite), .mem_dest(s_mem_dest),
        .wb_valid(s_wb_valid), .wb_regwrite(s_wb_regwrite), .wb_memtoreg(s_wb_memtoreg),
        .wb_link(s_wb_link), .wb_dest(s_wb_dest), .pc_write_en(s_pc_write_en),
        .ifid_write_en(s_ifid_write_en), .ifid_flush(s_ifid_flush), .redirect(s_redirect),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [9:0] c, input logic bne,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        id_valid = v; id_ctrl = c; id_bne = bne; id_rs = rs; id_rt = rt; id_rd = rd;
        #1;
    endtask

    task automatic bubble();
        drive(1'b0, 10'd0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask

    initial begin
        rst_n = 1'b0; hold = 1'b0; ex_zero = 1'b0;
        bubble();
        chk("rst_ex_valid", 32'(ex_valid), 0);
        chk("rst_wb_valid", 32'(wb_valid), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        chk("rst_pc_we", 32'(pc_write_en), 1);
        chk("rst_ifid_we", 32'(ifid_write_en), 1);
        chk("rst_flush", 32'(ifid_flush), 0);
        tick();
        rst_n = 1'b1;
        tick();

        // ADDI rt=5 latency through EX, MEM, WB
        drive(1'b1, C_ADDI, 1'b0, 5'd0, 5'd5, 5'd0);
        tick();
        bubble();
        chk("addi_ex_valid", 32'(ex_valid), 1);
        chk("addi_ex_dest", 32'(ex_dest), 5);
        chk("addi_ex_alusrc", 32'(ex_alusrc), 1);
        tick();
        chk("addi_mem_regwrite", 32'(mem_regwrite), 1);
        chk("addi_mem_dest", 32'(mem_dest), 5);
        tick();
        chk("addi_wb_regwrite", 32'(wb_regwrite), 1);
        chk("addi_wb_dest", 32'(wb_dest), 5);
        chk("addi_wb_valid", 32'(wb_valid), 1);

        // LW rt=8 then ADD rs=8: one stall cycle
        drive(1'b1, C_LW, 1'b0, 5'd1, 5'd8, 5'd0);
        tick();
        drive(1'b1, C_ADD, 1'b0, 5'd8, 5'd2, 5'd9);
        chk("lu_pc_we", 32'(pc_write_en), 0);
        chk("lu_ifid_we", 32'(ifid_write_en), 0);
        tick();
        chk("lu_ex_bubble", 32'(ex_valid), 0);
        chk("lu_mem_memread", 32'(mem_memread), 1);
        chk("lu_stall_cnt", 32'(stall_cnt), 1);
        chk("lu_pc_we_after", 32'(pc_write_en), 1);
        tick();
        bubble();
        chk("lu_add_ex_valid", 32'(ex_valid), 1);
        chk("lu_add_ex_dest", 32'(ex_dest), 9);
        chk("lu_stall_cnt_hold", 32'(stall_cnt), 1);
        tick();

        // BEQ taken: flush wrong-path ADDI
        drive(1'b1, C_BEQ, 1'b0, 5'd1, 5'd2, 5'd0);
        tick();
        chk("beq_ex_branch", 32'(ex_branch), 1);
        ex_zero = 1'b1;
        drive(1'b1, C_ADDI, 1'b0, 5'd0, 5'd7, 5'd0);
        chk("beq_flush", 32'(ifid_flush), 1);
        chk("beq_redirect", 32'(redirect), 1);
        chk("beq_pc_we", 32'(pc_write_en), 1);
        tick();
        bubble();
        chk("beq_ex_bubble", 32'(ex_valid), 0);
        chk("beq_mem_valid", 32'(mem_valid), 1);
        chk("beq_flush_cnt", 32'(flush_cnt), 1);
        chk("beq_flush_after", 32'(ifid_flush), 0);
        ex_zero = 1'b0;

        // BEQ not taken
        drive(1'b1, C_BEQ, 1'b0, 5'd1, 5'd2, 5'd0);
        tick();
        bubble();
        chk("beq_nt_flush", 32'(ifid_flush), 0);
        chk("beq_nt_redirect", 32'(redirect), 0);
        tick();

        // BNE with zero=0: taken
        drive(1'b1, C_BEQ, 1'b1, 5'd1, 5'd2, 5'd0);
        tick();
        bubble();
        chk("bne_ex_bne", 32'(ex_bne), 1);
        chk("bne_flush", 32'(ifid_flush), 1);
        tick();
        chk("bne_flush_cnt", 32'(flush_cnt), 2);

        // JAL: link register, flush in EX, wb_link
        drive(1'b1, C_JAL, 1'b0, 5'd0, 5'd0, 5'd0);
        tick();
        bubble();
        chk("jal_ex_dest", 32'(ex_dest), 31);
        chk("jal_ex_jump", 32'(ex_jump), 1);
        chk("jal_redirect", 32'(redirect), 1);
        tick();
        chk("jal_flush_cnt", 32'(flush_cnt), 3);
        tick();
        chk("jal_wb_link", 32'(wb_link), 1);
        chk("jal_wb_dest", 32'(wb_dest), 31);
        chk("jal_wb_regwrite", 32'(wb_regwrite), 1);

        // R-type to r0: write suppressed
        drive(1'b1, C_ADD, 1'b0, 5'd3, 5'd4, 5'd0);
        tick();
        bubble();
        tick();
        tick();
        chk("r0_wb_valid", 32'(wb_valid), 1);
        chk("r0_wb_regwrite", 32'(wb_regwrite), 0);
        chk("r0_wb_link", 32'(wb_link), 0);

        // Hold during a load-use case
        drive(1'b1, C_LW, 1'b0, 5'd1, 5'd8, 5'd0);
        tick();
        hold = 1'b1;
        drive(1'b1, C_ADD, 1'b0, 5'd8, 5'd2, 5'd9);
        chk("hold_pc_we", 32'(pc_write_en), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_ex_valid", 32'(ex_valid), 1);
            chk("hold_ex_dest", 32'(ex_dest), 8);
            chk("hold_stall_cnt", 32'(stall_cnt), 1);
        end
        hold = 1'b0;
        #1;
        chk("hold_rel_pc_we", 32'(pc_write_en), 0);
        tick();
        chk("hold_rel_stall_cnt", 32'(stall_cnt), 2);
        chk("hold_rel_ex_bubble", 32'(ex_valid), 0);
        bubble();
        tick();

        // Hold masks a taken branch
        drive(1'b1, C_BEQ, 1'b0, 5'd1, 5'd2, 5'd0);
        tick();
        bubble();
        ex_zero = 1'b1; hold = 1'b1;
        #1;
        chk("hold_taken_flush", 32'(ifid_flush), 0);
        chk("hold_taken_redirect", 32'(redirect), 0);
        tick();
        chk("hold_taken_flush_cnt", 32'(flush_cnt), 3);
        chk("hold_taken_ex_branch", 32'(ex_branch), 1);
        hold = 1'b0;
        #1;
        chk("hold_taken_rel_flush", 32'(ifid_flush), 1);
        tick();
        chk("hold_taken_rel_cnt", 32'(flush_cnt), 4);
        ex_zero = 1'b0;

        // Asynchronous reset mid-stream
        drive(1'b1, C_ADDI, 1'b0, 5'd0, 5'd5, 5'd0);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_ex_valid", 32'(ex_valid), 0);
        chk("arst_mem_valid", 32'(mem_valid), 0);
        chk("arst_stall_cnt", 32'(stall_cnt), 0);
        chk("arst_flush_cnt", 32'(flush_cnt), 0);
        bubble();
        tick();
        rst_n = 1'b1;
        tick();

        // Ten load-use stalls: 16-bit counter reaches 10, 3-bit counter saturates at 7
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, C_LW, 1'b0, 5'd0, 5'd8, 5'd0);
            tick();
            drive(1'b1, C_ADD, 1'b0, 5'd8, 5'd2, 5'd9);
            tick();
        end
        bubble();
        chk("sat_main_stall_cnt", 32'(stall_cnt), 10);
        chk("sat_narrow_stall_cnt", 32'(s_stall_cnt), 7);
        chk("sat_narrow_flush_cnt", 32'(s_flush_cnt), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
